// File: rtl/signed_mul_pkg.sv
// Shared types and constants for the sequential signed/unsigned multiplier.
// Holds the FSM state encoding and the fixed-latency figure for the default build.
package signed_mul_pkg;

    localparam int W_DEF       = 32;
    localparam int MUL_LATENCY = W_DEF + 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NEG_A = 3'd1,
        NEG_B = 3'd2,
        MUL   = 3'd3,
        NEG_P = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/neg_unit_64.sv
// Combinational two's-complement negate, shared by every negation step of the multiplier.
module neg_unit_64 #(
    parameter int N = 64
) (
    input  logic [N-1:0] in_i,
    output logic [N-1:0] out_o
);

    assign out_o = ~in_i + {{(N-1){1'b0}}, 1'b1};

endmodule

// File: rtl/signed_mul_seq.sv
// Sequential shift-add multiplier on operand magnitudes, one multiplier bit per cycle.
// Optional build macro SIGNED_MUL_EARLY_TERM_EN ends MUL once remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for start; product held
// NEG_A | take magnitude of the multiplicand
// NEG_B | take magnitude of the multiplier, load bit counter
// MUL   | shift-add, LSB first
// NEG_P | apply result sign to the accumulator
// DONE  | publish product, pulse done
module signed_mul_seq
    import signed_mul_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           sgn,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int P  = 2 * W;
    localparam int CW = $clog2(W) + 1;

    state_t          state_q;
    logic [P-1:0]    a_q;
    logic [P-1:0]    b_q;
    logic [P-1:0]    acc_q;
    logic            sgn_q;
    logic            res_neg_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic [P-1:0]    product_q;

    logic [P-1:0]    neg_in_d;
    logic [P-1:0]    neg_out;
    logic [P-1:0]    acc_d;
    logic            mul_last_d;

    neg_unit_64 #(.N(P)) u_neg (
        .in_i  (neg_in_d),
        .out_o (neg_out)
    );

    always_comb begin
        neg_in_d = '0;
        case (state_q)
            NEG_A:   neg_in_d = a_q;
            NEG_B:   neg_in_d = b_q;
            NEG_P:   neg_in_d = acc_q;
            default: neg_in_d = '0;
        endcase
    end

    always_comb begin
        acc_d = b_q[0] ? (acc_q + a_q) : acc_q;
`ifdef SIGNED_MUL_EARLY_TERM_EN
        // Bit 0 is consumed this cycle; stop if nothing above it can add anything.
        mul_last_d = (cnt_q == '0) || (b_q[P-1:1] == '0);
`else
        mul_last_d = (cnt_q == '0);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            sgn_q     <= 1'b0;
            res_neg_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q       <= {{W{sgn & a[W-1]}}, a};
                        b_q       <= {{W{sgn & b[W-1]}}, b};
                        sgn_q     <= sgn;
                        res_neg_q <= sgn & (a[W-1] ^ b[W-1]);
                        acc_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= NEG_A;
                    end
                end
                NEG_A: begin
                    if (sgn_q && a_q[P-1]) a_q <= neg_out;
                    state_q <= NEG_B;
                end
                NEG_B: begin
                    if (sgn_q && b_q[P-1]) b_q <= neg_out;
                    cnt_q   <= CW'(W - 1);
                    state_q <= MUL;
                end
                MUL: begin
                    acc_q <= acc_d;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q - 1'b1;
                    if (mul_last_d) state_q <= NEG_P;
                end
                NEG_P: begin
                    if (res_neg_q) acc_q <= neg_out;
                    state_q <= DONE;
                end
                DONE: begin
                    product_q <= acc_q;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_signed_mul_seq.sv
// Directed-vector bench for signed_mul_seq; honours SIGNED_MUL_EARLY_TERM_EN for latency checks.
module tb_signed_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int vectors     = 0;
    int miscompares = 0;

    signed_mul_seq #(.W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sgn     (sgn),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    // Launches one operation; lat = edges from acceptance to done, -1 on timeout.
    task automatic run_op(input logic s, input logic [31:0] av, input logic [31:0] bv,
                          output int lat, output logic [63:0] prod);
        @(negedge clk);
        sgn = s; a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat  = -1;
        prod = 'x;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat  = c;
                prod = product;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; sgn = 1'b0; a = 32'd9; b = 32'd9;
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b product=%h, want 0 0 0", busy, done, product);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_priority: busy=%b, want 0 (start under reset must be dropped)", busy);
        end
    endtask

    task automatic test_signed_basic();
        int          lat;
        logic [63:0] p;
        int          want_lat;
`ifdef SIGNED_MUL_EARLY_TERM_EN
        want_lat = 6;
`else
        want_lat = 36;
`endif
        run_op(1'b1, 32'd7, 32'hFFFF_FFFD, lat, p);
        vectors++;
        if (p !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            miscompares++;
            $display("FAIL mul_7x_m3: product=%h, want FFFFFFFFFFFFFFEB", p);
        end
        vectors++;
        if (lat !== want_lat) begin
            miscompares++;
            $display("FAIL latency_7x_m3: latency=%0d, want %0d", lat, want_lat);
        end
    endtask

    task automatic test_extremes();
        int          lat;
        logic [63:0] p;
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, lat, p);
        vectors++;
        if (p !== 64'h4000_0000_0000_0000) begin
            miscompares++;
            $display("FAIL min_neg_sq: product=%h, want 4000000000000000", p);
        end
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, p);
        vectors++;
        if (p !== 64'hFFFF_FFFE_0000_0001) begin
            miscompares++;
            $display("FAIL umax_sq: product=%h, want FFFFFFFE00000001", p);
        end
        run_op(1'b1, 32'd0, 32'hFFFF_FFFF, lat, p);
        vectors++;
        if (p !== 64'd0) begin
            miscompares++;
            $display("FAIL zero_x_m1: product=%h, want 0", p);
        end
        run_op(1'b1, 32'hFFFF_FFFF, 32'd1, lat, p);
        vectors++;
        if (p !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            miscompares++;
            $display("FAIL m1_x_1: product=%h, want FFFFFFFFFFFFFFFF", p);
        end
        run_op(1'b0, 32'h8000_0000, 32'd3, lat, p);
        vectors++;
        if (p !== 64'h0000_0001_8000_0000) begin
            miscompares++;
            $display("FAIL unsigned_msb_x3: product=%h, want 0000000180000000", p);
        end
    endtask

    task automatic test_early_term();
        int          lat;
        logic [63:0] p;
        int          want_lat;
`ifdef SIGNED_MUL_EARLY_TERM_EN
        want_lat = 5;
`else
        want_lat = 36;
`endif
        run_op(1'b0, 32'd5, 32'd1, lat, p);
        vectors++;
        if (p !== 64'd5) begin
            miscompares++;
            $display("FAIL mul_5x1: product=%h, want 5", p);
        end
        vectors++;
        if (lat !== want_lat) begin
            miscompares++;
            $display("FAIL latency_5x1: latency=%0d, want %0d", lat, want_lat);
        end
    endtask

    task automatic test_ignore_start();
        int          dones = 0;
        int          first_done = -1;
        logic [63:0] p = 'x;
        @(negedge clk);
        sgn = 1'b0; a = 32'd100; b = 32'd200; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 5 || c == 20) begin
                sgn = 1'b1; a = 32'd3; b = 32'hFFFF_FFFF; start = 1'b1;
            end
            @(posedge clk);
            #1 start = 1'b0;
            if (done) begin
                dones++;
                if (first_done < 0) begin
                    first_done = c;
                    p = product;
                end
            end
            if (dones > 0 && !busy && c > 40) break;
        end
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("FAIL ignore_start_dones: done pulses=%0d, want 1", dones);
        end
        vectors++;
        if (p !== 64'd20000) begin
            miscompares++;
            $display("FAIL ignore_start_product: product=%h, want 0000000000004E20", p);
        end
    endtask

    task automatic test_reset_mid();
        int          lat;
        logic [63:0] p;
        int          dones = 0;
        @(negedge clk);
        sgn = 1'b0; a = 32'd1000; b = 32'd1000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        // MUL occupies cycles 2..33, so cycle 12 is its tenth-plus cycle
        for (int c = 1; c < 12; c++) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || product !== 64'd0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%b done=%b product=%h, want 0 0 0", busy, done, product);
        end
        rst = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL reset_abort_done: done pulses=%0d, want 0", dones);
        end
        run_op(1'b1, 32'd3, 32'd4, lat, p);
        vectors++;
        if (p !== 64'd12) begin
            miscompares++;
            $display("FAIL after_reset_3x4: product=%h, want 000000000000000C", p);
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [63:0] p;
        logic        seen = 1'b0;
        run_op(1'b1, 32'hFFFF_FFFE, 32'd6, lat, p);
        vectors++;
        if (p !== 64'hFFFF_FFFF_FFFF_FFF4) begin
            miscompares++;
            $display("FAIL b2b_first: product=%h, want FFFFFFFFFFFFFFF4", p);
        end
        // done is high now; request the next op for the very next edge
        sgn = 1'b1; a = 32'hFFFF_FFFB; b = 32'hFFFF_FFF9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_accept: busy=%b, want 1", busy);
        end
        p = 'x;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (c == 1 && product !== 64'hFFFF_FFFF_FFFF_FFF4) begin
                vectors++;
                miscompares++;
                $display("FAIL b2b_hold: product=%h, want FFFFFFFFFFFFFFF4", product);
            end
            if (done) begin
                seen = 1'b1;
                p = product;
                break;
            end
        end
        vectors++;
        if (!seen || p !== 64'd35) begin
            miscompares++;
            $display("FAIL b2b_second: done_seen=%b product=%h, want 1 0000000000000023", seen, p);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_signed_basic();
        test_extremes();
        test_early_term();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
